// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: default word/tag/buffer sizes, Q7.8 format,
// pipeline latency and the signed saturation limits of a Q7.8 word.
package cordic_pkg;

  localparam int unsigned CORDIC_DATA_WIDTH = 16;
  localparam int unsigned CORDIC_FLIP_WIDTH = 1;
  localparam int unsigned CORDIC_FIFO_DEPTH = 8;

  localparam int unsigned Q_INT_BITS  = 7;
  localparam int unsigned Q_FRAC_BITS = 8;

  localparam int unsigned CORDIC_LATENCY = 6;

  localparam logic [CORDIC_DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [CORDIC_DATA_WIDTH-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/cordic_res_fifo.sv
// Synchronous result FIFO; the head is visible combinationally and reads as 0 when empty.
// A write while full is accepted only if a read retires an entry in the same cycle.
module cordic_res_fifo #(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PONE_C  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             push_s, pop_s, empty_s;

  assign empty_s   = (occ_q == '0);
  assign full      = (occ_q == DEPTH_C);
  assign pop_s     = rd_en & ~empty_s;
  assign push_s    = wr_en & (~full | pop_s);
  assign occupancy = occ_q;
  assign rd_data   = empty_s ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is deliberately not reset; it is hidden behind the empty gate on rd_data.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/cordic_result_collector.sv
// Collects CORDIC results: undoes the quadrant flip with saturating negation,
// buffers results for the consumer and tracks issue credits and protocol errors.
module cordic_result_collector
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = CORDIC_DATA_WIDTH,
  parameter int unsigned FLIP_FLAG_WIDTH = CORDIC_FLIP_WIDTH,
  parameter int unsigned FIFO_DEPTH      = CORDIC_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        degree_in,
  input  logic [DATA_WIDTH-1:0]        x_in,
  input  logic [DATA_WIDTH-1:0]        y_in,
  input  logic [FLIP_FLAG_WIDTH-1:0]   flip_in,
  input  logic                         arctan_en_in,
  input  logic                         valid_in,
  input  logic                         issue_fire,
  output logic                         issue_ok,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DATA_WIDTH-1:0]        res_degree,
  output logic [DATA_WIDTH-1:0]        res_x,
  output logic [DATA_WIDTH-1:0]        res_y,
  output logic [FLIP_FLAG_WIDTH-1:0]   res_flip,
  output logic                         res_arctan,
  output logic [$clog2(FIFO_DEPTH):0]  occupancy,
  output logic [$clog2(FIFO_DEPTH):0]  inflight,
  output logic                         err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = 3 * DATA_WIDTH + FLIP_FLAG_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [DATA_WIDTH-1:0] POS_LIM = (DATA_WIDTH == CORDIC_DATA_WIDTH) ?
    DATA_WIDTH'(SAT_MAX) : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_LIM = (DATA_WIDTH == CORDIC_DATA_WIDTH) ?
    DATA_WIDTH'(SAT_MIN) : {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // The most negative word has no positive twin, so it clamps to the positive limit.
  function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] v);
    if (v == NEG_LIM) begin
      sat_neg = POS_LIM;
    end else begin
      sat_neg = (~v) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         occ_s;
  logic                  full_s, pop_s;
  logic [CW:0]           credit_sum_s;
  logic [DATA_WIDTH-1:0] x_corr_s, y_corr_s;
  logic [EW-1:0]         wr_data_s, rd_data_s;

  always_comb begin
    x_corr_s = x_in;
    y_corr_s = y_in;
    if (!arctan_en_in && flip_in[0]) begin
      x_corr_s = sat_neg(x_in);
      y_corr_s = sat_neg(y_in);
    end else begin
      x_corr_s = x_in;
      y_corr_s = y_in;
    end
  end

  assign wr_data_s = {flip_in, arctan_en_in, degree_in, x_corr_s, y_corr_s};

  cordic_res_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en     (valid_in),
    .wr_data   (wr_data_s),
    .rd_en     (pop_s),
    .rd_data   (rd_data_s),
    .occupancy (occ_s),
    .full      (full_s)
  );

  assign res_valid  = (occ_s != '0);
  assign pop_s      = res_valid & res_ready;
  assign res_flip   = rd_data_s[EW-1 -: FLIP_FLAG_WIDTH];
  assign res_arctan = rd_data_s[3*DATA_WIDTH];
  assign res_degree = rd_data_s[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign res_x      = rd_data_s[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign res_y      = rd_data_s[DATA_WIDTH-1:0];

  // A credit is held from launch until the result lands in the buffer.
  assign credit_sum_s = {1'b0, occ_s} + {1'b0, inflight_q};
  assign issue_ok     = (credit_sum_s < {1'b0, DEPTH_C});
  assign occupancy    = occ_s;
  assign inflight     = inflight_q;
  assign err          = err_q;

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_fire, valid_in})
      2'b10: begin
        if (inflight_q < DEPTH_C) begin
          inflight_d = inflight_q + ONE_C;
        end else begin
          inflight_d = inflight_q;
        end
      end
      2'b01: begin
        if (inflight_q != '0) begin
          inflight_d = inflight_q - ONE_C;
        end else begin
          inflight_d = inflight_q;
        end
      end
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q
          | (issue_fire & ~issue_ok)
          | (valid_in & (inflight_q == '0))
          | (valid_in & full_s & ~pop_s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed bench for cordic_result_collector: vector table for the correction
// path plus hand-written sequences for credit, full/pop, error and reset cases.
module tb_cordic_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] degree_in, x_in, y_in;
  logic [0:0]  flip_in;
  logic        arctan_en_in, valid_in, issue_fire, res_ready;
  logic        issue_ok, res_valid, res_arctan, err;
  logic [15:0] res_degree, res_x, res_y;
  logic [0:0]  res_flip;
  logic [3:0]  occupancy, inflight;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [15:0] deg;
    logic [15:0] x;
    logic [15:0] y;
    logic        flip;
    logic        arct;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  cordic_result_collector dut (
    .clk          (clk),
    .reset        (reset),
    .degree_in    (degree_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .flip_in      (flip_in),
    .arctan_en_in (arctan_en_in),
    .valid_in     (valid_in),
    .issue_fire   (issue_fire),
    .issue_ok     (issue_ok),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_degree   (res_degree),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_flip     (res_flip),
    .res_arctan   (res_arctan),
    .occupancy    (occupancy),
    .inflight     (inflight),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; inputs return to idle afterwards.
  task automatic drive(input logic fire, input logic vld, input logic rdy,
                       input logic [15:0] deg, input logic [15:0] x,
                       input logic [15:0] y, input logic flip, input logic arct);
    issue_fire = fire; valid_in = vld; res_ready = rdy;
    degree_in = deg; x_in = x; y_in = y; flip_in = flip; arctan_en_in = arct;
    tick();
    issue_fire = 1'b0; valid_in = 1'b0; res_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'h0100, 16'h0080, 1'b1, 1'b0, 16'hFF00, 16'hFF80};
    vecs[1] = '{16'h0020, 16'h8000, 16'h1234, 1'b1, 1'b0, 16'h7FFF, 16'hEDCC};
    vecs[2] = '{16'h0030, 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h8000, 16'h8000};
    vecs[3] = '{16'h0040, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 16'hFFFF};
    vecs[4] = '{16'h0050, 16'h0100, 16'hFF00, 1'b0, 1'b0, 16'h0100, 16'hFF00};
    vecs[5] = '{16'h0060, 16'h0000, 16'h8001, 1'b1, 1'b0, 16'h0000, 16'h7FFF};
    vecs[6] = '{16'h0070, 16'hABCD, 16'h0000, 1'b0, 1'b1, 16'hABCD, 16'h0000};

    reset = 1'b0;
    issue_fire = 1'b0; valid_in = 1'b0; res_ready = 1'b0;
    degree_in = 16'h0000; x_in = 16'h0000; y_in = 16'h0000;
    flip_in = 1'b0; arctan_en_in = 1'b0;
    #12;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_issue_ok", issue_ok, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    chk("rst_res_x", res_x, 0);
    reset = 1'b1;
    tick();

    // Correction table: one op issued, returned, inspected, popped.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, vecs[i].deg, vecs[i].x, vecs[i].y, vecs[i].flip, vecs[i].arct);
      chk($sformatf("vec%0d_valid", i), res_valid, 1);
      chk($sformatf("vec%0d_x", i), res_x, vecs[i].exp_x);
      chk($sformatf("vec%0d_y", i), res_y, vecs[i].exp_y);
      chk($sformatf("vec%0d_deg", i), res_degree, vecs[i].deg);
      chk($sformatf("vec%0d_flip", i), res_flip, vecs[i].flip);
      chk($sformatf("vec%0d_arct", i), res_arctan, vecs[i].arct);
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      chk($sformatf("vec%0d_occ_after_pop", i), occupancy, 0);
    end
    chk("table_err", err, 0);
    chk("table_inflight", inflight, 0);

    // Back-to-back results with the consumer always ready.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("b2b_inflight", inflight, 3);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 16'(k), 16'h0100, 16'h0080, 1'b1, 1'b0);
      chk($sformatf("b2b%0d_valid", k), res_valid, 1);
      chk($sformatf("b2b%0d_deg", k), res_degree, k);
      chk($sformatf("b2b%0d_x", k), res_x, 16'hFF00);
      chk($sformatf("b2b%0d_y", k), res_y, 16'hFF80);
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("b2b_occ_end", occupancy, 0);
    chk("b2b_inflight_end", inflight, 0);

    // Launch and return in the same cycle leaves inflight unchanged.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'd40, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("sim_fire_valid_inflight", inflight, 2);
    chk("sim_fire_valid_occ", occupancy, 1);
    chk("sim_fire_valid_err", err, 0);
    drive(1'b0, 1'b1, 1'b1, 16'd41, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'd42, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("drain1_occ", occupancy, 0);
    chk("drain1_inflight", inflight, 0);
    chk("drain1_err", err, 0);

    // Credit limit: eight launches exhaust the buffer credits.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      if (i == 6) chk("credit_ok_after7", issue_ok, 1);
    end
    chk("credit_ok_after8", issue_ok, 0);
    chk("credit_inflight8", inflight, 8);
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, 1'b0, 16'(10 + i), 16'(i), 16'h0000, 1'b0, 1'b0);
    chk("full_occ", occupancy, 8);
    chk("full_inflight", inflight, 0);
    chk("full_issue_ok", issue_ok, 0);
    chk("full_err", err, 0);
    chk("full_head", res_degree, 10);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("pop_issue_ok", issue_ok, 1);
    chk("pop_occ", occupancy, 7);
    chk("pop_head", res_degree, 11);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'd18, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("refill_occ", occupancy, 8);
    chk("refill_err", err, 0);

    // Full with no pop: result dropped, head untouched, error raised.
    drive(1'b0, 1'b1, 1'b0, 16'd30, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("drop_occ", occupancy, 8);
    chk("drop_head", res_degree, 11);
    chk("drop_err", err, 1);

    // Full with a pop: both happen, the new entry goes to the tail.
    drive(1'b0, 1'b1, 1'b1, 16'd19, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("fullpop_occ", occupancy, 8);
    chk("fullpop_head", res_degree, 12);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain2_%0d_deg", k), res_degree, (k < 7) ? 12 + k : 19);
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    end
    chk("drain2_valid", res_valid, 0);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("pop_empty_occ", occupancy, 0);

    // Unexpected return with nothing in flight: accepted, error is sticky.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 16'd50, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("orphan_err", err, 1);
    chk("orphan_occ", occupancy, 1);
    chk("orphan_inflight", inflight, 0);
    chk("orphan_deg", res_degree, 50);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("orphan_err_sticky", err, 1);

    // Over-issue: counted up to the buffer depth, then flagged.
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("overissue_pre_err", err, 0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("overissue_inflight_sat", inflight, 8);
    chk("overissue_err", err, 1);

    // Reset mid-operation takes effect without a clock edge.
    do_reset();
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b0, 16'(60 + i), 16'h1111, 16'h2222, 1'b0, 1'b0);
    chk("midrst_pre_occ", occupancy, 4);
    chk("midrst_pre_inflight", inflight, 2);
    reset = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_inflight", inflight, 0);
    chk("midrst_err", err, 0);
    chk("midrst_issue_ok", issue_ok, 1);
    chk("midrst_res_x", res_x, 0);
    #2;
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/cordic_result_collector.md
CORDIC_RESULT_COLLECTOR -- requirements
Module: cordic_result_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed Q7.8 word width of all result fields.
REQ-002 SHALL have parameter FLIP_FLAG_WIDTH, default 1, meaning width of the quadrant-flip tag.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2), meaning result-buffer entries.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset  in  1  async active-low reset.
REQ-005 SHALL have the following pipeline-side inputs: degree_in, x_in and y_in (in, DATA_WIDTH each, CORDIC result words); flip_in (in, FLIP_FLAG_WIDTH, flip tag); arctan_en_in (in, 1, 1=vectoring result); valid_in (in, 1, result present this cycle, no backpressure possible).
REQ-006 SHALL have the following issue-side ports: issue_fire (in, 1, issuer launched one op into the CORDIC pipeline this cycle); issue_ok (out, 1, issuer may launch this cycle).
REQ-007 SHALL have the following consumer-side ports: res_valid (out, 1); res_ready (in, 1); res_degree, res_x and res_y (out, DATA_WIDTH each); res_flip (out, FLIP_FLAG_WIDTH); res_arctan (out, 1).
REQ-008 SHALL have the following status ports: occupancy (out, clog2(FIFO_DEPTH)+1, stored entries); inflight (out, clog2(FIFO_DEPTH)+1, launched but not yet returned); err (out, 1, sticky protocol error).

Function
REQ-009 SHALL, on valid_in=1, write the corrected result into the FIFO at that clk edge, so that res_valid can first be 1 in the following cycle.
REQ-010 SHALL apply this correction before the write: if arctan_en_in=0 and flip_in[0]=1, x and y are negated with saturation (-32768 -> +32767); otherwise x and y pass unchanged; degree always passes unchanged; flip and arctan are stored verbatim.
REQ-011 SHALL present the FIFO head combinationally on res_* with res_valid = (occupancy != 0); an entry pops on res_valid & res_ready.
REQ-012 SHALL keep res_* data stable while res_valid=1 and res_ready=0.
REQ-013 SHALL compute issue_ok = (occupancy + inflight) < FIFO_DEPTH, combinationally from registered counters.
REQ-014 SHALL update inflight as +1 on issue_fire, -1 on valid_in, and unchanged when both occur in the same cycle.
REQ-015 SHALL, on issue_fire while issue_ok=0, still count the op in inflight (saturating at FIFO_DEPTH) and set err.
REQ-016 SHALL, on valid_in while inflight=0, hold inflight at 0, still accept the result if space exists, and set err.
REQ-017 SHALL, on valid_in while full with no pop that cycle, drop the result, set err, and leave occupancy and head unchanged.
REQ-018 SHALL, on valid_in while full with a pop in the same cycle, perform both; occupancy stays at FIFO_DEPTH.
REQ-019 SHALL, on a pop while empty, do nothing.
REQ-020 SHALL wrap read and write pointers modulo FIFO_DEPTH, with full/empty derived from occupancy.
REQ-021 SHALL keep err set until reset.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear pointers, occupancy, inflight and err; res_valid=0, issue_ok=1, and res_* data read as 0.
REQ-023 SHALL discard results of ops in flight when reset is asserted mid-operation; the issuer and pipeline are reset together.
REQ-024 SHALL NOT clear FIFO storage on reset; storage is unobservable while empty.

Structure
REQ-025 SHALL take DATA_WIDTH, FLIP_FLAG_WIDTH, FIFO_DEPTH defaults, the Q7.8 format constants, CORDIC pipeline latency (6) and the saturation limits from shared package cordic_pkg.
REQ-026 SHALL instantiate one sub-module, cordic_res_fifo (synchronous FIFO, async active-low reset), and keep the correction and credit logic in the top level.

Verification
REQ-027 SHALL cover back-to-back results: issue 3 ops, valid_in with x=0x0100, y=0x0080, flip=1, arctan_en=0, res_ready=1 -> res_x=0xFF00, res_y=0xFF80 one cycle later, in order.
REQ-028 SHALL cover saturation: x_in=0x8000, flip=1, arctan_en=0 -> res_x=0x7FFF; same input with arctan_en=1 -> res_x=0x8000, degree unchanged.
REQ-029 SHALL cover credit limit: res_ready=0, issue 8 ops -> issue_ok=0 after the 8th; 8 returns fill FIFO; one pop -> issue_ok=1 next cycle.
REQ-030 SHALL cover simultaneous events: full FIFO, valid_in together with a pop -> occupancy stays 8, new entry at tail, err=0; issue_fire with valid_in -> inflight unchanged.
REQ-031 SHALL cover errors: valid_in with inflight=0 -> err=1 sticky; valid_in when full with no pop -> entry dropped, head unchanged, err=1.
REQ-032 SHALL cover mid-operation reset: assert reset with 4 entries and 2 in flight -> res_valid=0, occupancy=0, inflight=0, err=0, issue_ok=1 immediately, without waiting for a clock edge.
